// File: rtl/snn_readout_pkg.sv
// snn_readout_pkg
//   Shared defaults and state encodings for the spike-rate readout block.
//   DEF_NUM_NEURONS : number of output neurons counted
//   DEF_CNT_W       : per-neuron spike counter width
//   DEF_WIN_W       : window-length register width
//   IDX_W           : neuron index width for the default neuron count
//   acc_state_e     : accumulator FSM (IDLE, ACCUM)
//   drn_state_e     : drain FSM (EMPTY, DRAIN)
package snn_readout_pkg;

  localparam int DEF_NUM_NEURONS = 8;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_WIN_W       = 8;
  localparam int IDX_W           = $clog2(DEF_NUM_NEURONS);

  typedef enum logic {
    ACC_IDLE  = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_e;

  typedef enum logic {
    DRN_EMPTY = 1'b0,
    DRN_DRAIN = 1'b1
  } drn_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   One per-neuron spike counter with increment and synchronous clear.
//   With SPIKE_RATE_OVERFLOW_EN defined the count saturates at 2^CNT_W-1 and
//   sat_hit_o flags an increment attempted at the maximum; otherwise it wraps.
// Ports:
//   system_clock   in   clock
//   sys_clk_reset  in   asynchronous active-high reset
//   clr_i          in   clear count (wins over the increment for the register)
//   inc_i          in   add one this cycle
//   next_o         out  count after this cycle's increment, before any clear
//   sat_hit_o      out  increment attempted at max (SPIKE_RATE_OVERFLOW_EN only)
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             system_clock,
  input  logic             sys_clk_reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] next_o
`ifdef SPIKE_RATE_OVERFLOW_EN
  ,
  output logic             sat_hit_o
`endif
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

`ifdef SPIKE_RATE_OVERFLOW_EN
  logic at_max;
  assign at_max    = &cnt_q;
  assign sat_hit_o = inc_i && at_max;
  assign next_o    = (inc_i && !at_max) ? cnt_q + CNT_W'(1) : cnt_q;
`else
  assign next_o    = cnt_q + {{(CNT_W-1){1'b0}}, inc_i};
`endif

  // next_o is still exported on a clear so the parent can snapshot the
  // final value of a window in the same cycle the counter restarts.
  assign cnt_d = clr_i ? '0 : next_o;

  always_ff @(posedge system_clock or posedge sys_clk_reset) begin
    if (sys_clk_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spike_rate_readout.sv
// spike_rate_readout
//   Counts layer-2 output spikes per neuron over a window of SNN steps,
//   snapshots the counts into a shadow bank at window end and drains them one
//   neuron at a time over a valid/ack handshake.
//   Optional macro: SPIKE_RATE_OVERFLOW_EN (saturating counters + overflow flag).
// Ports:
//   system_clock   in   clock
//   sys_clk_reset  in   asynchronous active-high reset
//   enable         in   accumulation enable
//   window_len     in   steps per window, 0 means 2^WIN_W
//   spikes_valid   in   one-cycle strobe per SNN step
//   spikes_in      in   spike vector qualified by spikes_valid
//   rd_ack         in   consumer accepts current cnt_data
//   cnt_valid      out  cnt_data/cnt_idx valid
//   cnt_data       out  count of neuron cnt_idx
//   cnt_idx        out  neuron index
//   window_done    out  one-cycle pulse after the last neuron is acked
//   overrun        out  sticky: window ended while a drain was in progress
//   overflow       out  sticky: a counter saturated (macro builds only)
module spike_rate_readout
  import snn_readout_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WIN_W       = DEF_WIN_W
) (
  input  logic                           system_clock,
  input  logic                           sys_clk_reset,
  input  logic                           enable,
  input  logic [WIN_W-1:0]               window_len,
  input  logic                           spikes_valid,
  input  logic [NUM_NEURONS-1:0]         spikes_in,
  input  logic                           rd_ack,
  output logic                           cnt_valid,
  output logic [CNT_W-1:0]               cnt_data,
  output logic [$clog2(NUM_NEURONS)-1:0] cnt_idx,
  output logic                           window_done,
  output logic                           overrun,
  output logic                           overflow
);

  localparam int IDX_BITS = $clog2(NUM_NEURONS);

  acc_state_e             acc_q, acc_d;
  drn_state_e             drn_q, drn_d;
  logic [WIN_W-1:0]       step_q, step_d;
  logic [WIN_W-1:0]       last_step;
  logic                   accum_step;
  logic                   win_end;
  logic                   cnt_clr;
  logic [NUM_NEURONS-1:0] cnt_inc;
  logic [CNT_W-1:0]       cnt_next [NUM_NEURONS];
  logic [CNT_W-1:0]       shadow_q [NUM_NEURONS];
  logic [IDX_BITS-1:0]    idx_q, idx_d, idx_inc;
  logic                   idx_last;
  logic [CNT_W-1:0]       data_q, data_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic                   snap_load;

`ifdef SPIKE_RATE_OVERFLOW_EN
  logic [NUM_NEURONS-1:0] sat_hit;
  logic                   overflow_q;
`endif

  // A step only counts while already in ACCUM with enable still high; the
  // cycle enable drops is the one that leaves ACCUM and its strobe is ignored.
  assign accum_step = (acc_q == ACC_ACCUM) && enable && spikes_valid;
  // window_len of 0 wraps to all-ones, giving a 2^WIN_W step window.
  assign last_step  = window_len - WIN_W'(1);
  assign win_end    = accum_step && (step_q == last_step);
  assign cnt_clr    = (acc_q != ACC_ACCUM) || !enable || win_end;
  assign cnt_inc    = accum_step ? spikes_in : '0;

  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_cnt
    sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .system_clock (system_clock),
      .sys_clk_reset(sys_clk_reset),
      .clr_i        (cnt_clr),
      .inc_i        (cnt_inc[gi]),
      .next_o       (cnt_next[gi])
`ifdef SPIKE_RATE_OVERFLOW_EN
      ,
      .sat_hit_o    (sat_hit[gi])
`endif
    );
  end

  // Accumulator next state.
  always_comb begin
    acc_d  = acc_q;
    step_d = step_q;
    case (acc_q)
      ACC_IDLE: begin
        step_d = '0;
        if (enable) acc_d = ACC_ACCUM;
      end
      ACC_ACCUM: begin
        if (!enable) begin
          acc_d  = ACC_IDLE;
          step_d = '0;
        end else if (win_end) begin
          step_d = '0;
        end else if (spikes_valid) begin
          step_d = step_q + WIN_W'(1);
        end
      end
      default: begin
        acc_d  = ACC_IDLE;
        step_d = '0;
      end
    endcase
  end

  assign idx_inc  = idx_q + IDX_BITS'(1);
  assign idx_last = (idx_q == IDX_BITS'(NUM_NEURONS - 1));

  // Drain next state. cnt_data is registered and preloaded with the next
  // shadow entry on each ack so rd_ack never reaches the outputs combinationally.
  always_comb begin
    drn_d     = drn_q;
    idx_d     = idx_q;
    data_d    = data_q;
    done_d    = 1'b0;
    snap_load = 1'b0;
    overrun_d = overrun_q | (win_end && (drn_q == DRN_DRAIN));
    case (drn_q)
      DRN_EMPTY: begin
        if (win_end) begin
          snap_load = 1'b1;
          drn_d     = DRN_DRAIN;
          idx_d     = '0;
          data_d    = cnt_next[0];
        end
      end
      DRN_DRAIN: begin
        if (rd_ack) begin
          if (idx_last) begin
            drn_d  = DRN_EMPTY;
            idx_d  = '0;
            data_d = '0;
            done_d = 1'b1;
          end else begin
            idx_d  = idx_inc;
            data_d = shadow_q[idx_inc];
          end
        end
      end
      default: begin
        drn_d  = DRN_EMPTY;
        idx_d  = '0;
        data_d = '0;
      end
    endcase
  end

  always_ff @(posedge system_clock or posedge sys_clk_reset) begin
    if (sys_clk_reset) begin
      acc_q     <= ACC_IDLE;
      step_q    <= '0;
      drn_q     <= DRN_EMPTY;
      idx_q     <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      step_q    <= step_d;
      drn_q     <= drn_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Shadow bank takes all neurons in parallel, so it stays in flops.
  always_ff @(posedge system_clock or posedge sys_clk_reset) begin
    if (sys_clk_reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) shadow_q[i] <= '0;
    end else if (snap_load) begin
      for (int i = 0; i < NUM_NEURONS; i++) shadow_q[i] <= cnt_next[i];
    end
  end

`ifdef SPIKE_RATE_OVERFLOW_EN
  always_ff @(posedge system_clock or posedge sys_clk_reset) begin
    if (sys_clk_reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q | (|sat_hit);
    end
  end
  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign cnt_valid   = (drn_q == DRN_DRAIN);
  assign cnt_idx     = idx_q;
  assign cnt_data    = data_q;
  assign window_done = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_spike_rate_readout.sv
module tb_spike_rate_readout;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] data;
  } exp_t;

  logic       system_clock = 1'b0;
  logic       sys_clk_reset;
  logic       enable;
  logic [7:0] window_len;
  logic       spikes_valid;
  logic [7:0] spikes_in;
  logic       rd_ack;
  logic       cnt_valid;
  logic [7:0] cnt_data;
  logic [2:0] cnt_idx;
  logic       window_done;
  logic       overrun;
  logic       overflow;

  int   tests  = 0;
  int   failed = 0;
  exp_t sb[$];
  logic done_pend = 1'b0;

  initial forever #5 system_clock = ~system_clock;

  spike_rate_readout dut (
    .system_clock (system_clock),
    .sys_clk_reset(sys_clk_reset),
    .enable       (enable),
    .window_len   (window_len),
    .spikes_valid (spikes_valid),
    .spikes_in    (spikes_in),
    .rd_ack       (rd_ack),
    .cnt_valid    (cnt_valid),
    .cnt_data     (cnt_data),
    .cnt_idx      (cnt_idx),
    .window_done  (window_done),
    .overrun      (overrun),
    .overflow     (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  task automatic push(input int idx, input int data);
    exp_t e;
    e.idx  = 3'(idx);
    e.data = 8'(data);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge system_clock);
    #1;
  endtask

  // One SNN step strobe, starting and ending just after a rising edge.
  task automatic step(input logic [7:0] vec);
    spikes_valid = 1'b1;
    spikes_in    = vec;
    tick();
    spikes_valid = 1'b0;
    spikes_in    = 8'h00;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 200 && sb.size() != 0; c++) tick();
    chk(name, sb.size(), 0);
    repeat (3) tick();
  endtask

  // Monitor: checks every accepted handshake against the scoreboard and the
  // window_done pulse one cycle after the last neuron is acked.
  initial begin
    exp_t e;
    forever begin
      @(negedge system_clock);
      if (sys_clk_reset) begin
        done_pend = 1'b0;
      end else begin
        if (done_pend || window_done) chk("window_done", window_done, done_pend);
        done_pend = 1'b0;
        if (cnt_valid && rd_ack) begin
          if (sb.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_output: got idx %0d data %0d expected none", cnt_idx, cnt_data);
          end else begin
            e = sb.pop_front();
            chk("cnt_idx", cnt_idx, e.idx);
            chk("cnt_data", cnt_data, e.data);
          end
          if (cnt_idx == 3'd7) done_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    sys_clk_reset = 1'b1;
    enable        = 1'b0;
    window_len    = 8'd4;
    spikes_valid  = 1'b0;
    spikes_in     = 8'h00;
    rd_ack        = 1'b0;
    repeat (3) tick();
    chk("rst_cnt_valid", cnt_valid, 0);
    chk("rst_cnt_data", cnt_data, 0);
    chk("rst_cnt_idx", cnt_idx, 0);
    chk("rst_window_done", window_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_overflow", overflow, 0);
    sys_clk_reset = 1'b0;
    tick();

    // Test 1: window of 4 all-ones steps, continuous ack.
    enable = 1'b1;
    rd_ack = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) begin
      if (s == 3) for (int i = 0; i < 8; i++) push(i, 4);
      step(8'hFF);
    end
    chk("t1_valid_latency", cnt_valid, 1);
    chk("t1_first_idx", cnt_idx, 0);
    wait_drain("t1_drain_complete");

    // Test 2: window of 3, neuron 2 spikes on steps 1 and 3.
    window_len = 8'd3;
    step(8'h04);
    step(8'h00);
    for (int i = 0; i < 8; i++) push(i, (i == 2) ? 2 : 0);
    step(8'h04);
    wait_drain("t2_drain_complete");

    // Test 3: hold ack while a second window ends -> overrun, window 1 kept.
    window_len = 8'd2;
    rd_ack     = 1'b0;
    step(8'h01);
    push(0, 2);
    push(1, 1);
    for (int i = 2; i < 8; i++) push(i, 0);
    step(8'h03);
    chk("t3_valid_held", cnt_valid, 1);
    chk("t3_data_held", cnt_data, 2);
    step(8'hFF);
    step(8'hFF);
    chk("t3_overrun", overrun, 1);
    chk("t3_data_kept", cnt_data, 2);
    rd_ack = 1'b1;
    wait_drain("t3_drain_complete");
    chk("t3_overrun_sticky", overrun, 1);

    // Test 4: drop enable mid-window; partial window discarded.
    window_len = 8'd4;
    step(8'hFF);
    step(8'hFF);
    enable = 1'b0;
    step(8'hFF);
    tick();
    chk("t4_no_snapshot", cnt_valid, 0);
    enable = 1'b1;
    tick();
    step(8'h02);
    step(8'h02);
    chk("t4_no_early_end", cnt_valid, 0);
    step(8'h02);
    for (int i = 0; i < 8; i++) push(i, (i == 1) ? 4 : 0);
    step(8'h02);
    wait_drain("t4_drain_complete");

    // Test 5: window_len 0 means 256 steps.
    window_len = 8'd0;
    for (int s = 1; s <= 300; s++) begin
      if (s == 256) begin
`ifdef SPIKE_RATE_OVERFLOW_EN
        push(0, 255);
`else
        push(0, 0);
`endif
        for (int i = 1; i < 8; i++) push(i, 0);
      end
      step(8'h01);
    end
`ifdef SPIKE_RATE_OVERFLOW_EN
    chk("t5_overflow", overflow, 1);
`else
    chk("t5_overflow", overflow, 0);
`endif
    enable = 1'b0;
    tick();
    wait_drain("t5_drain_complete");

    // Test 6: reset while the drain presents neuron 3.
    enable = 1'b1;
    tick();
    window_len = 8'd2;
    step(8'h0F);
    for (int i = 0; i < 3; i++) push(i, 2);
    step(8'h0F);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (cnt_valid && cnt_idx == 3'd3) found = 1'b1;
      else tick();
    end
    chk("t6_reached_idx3", found, 1);
    sys_clk_reset = 1'b1;
    enable        = 1'b0;
    #1;
    chk("t6_valid_async", cnt_valid, 0);
    tick();
    chk("t6_cnt_valid", cnt_valid, 0);
    chk("t6_cnt_idx", cnt_idx, 0);
    chk("t6_cnt_data", cnt_data, 0);
    chk("t6_window_done", window_done, 0);
    chk("t6_overrun", overrun, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_scoreboard_empty", sb.size(), 0);
    sys_clk_reset = 1'b0;
    repeat (4) tick();
    chk("t6_no_done_after", window_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
